// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data.
// A push while full is still written when a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;
  assign dout  = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; empty/count gate every read, so
  // stale contents are never observed and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: CPU pushes bytes into a FIFO that is serialised
// LSB-first on txd. Define UART_TX_PARITY_EN for 8E1 frames (default 8N1).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      _uart_in,
  input  logic [UART_DATA_BITS-1:0] data,
  output logic                      txd,
  output logic                      do_ready,
  output logic                      tx_busy,
  output logic                      overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(UART_DATA_BITS);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(UART_DATA_BITS - 1);
  localparam logic [IW-1:0] BIT_ONE   = IW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);

  uart_state_t               state, state_nxt;
  logic [BW-1:0]             baud, baud_nxt;
  logic [IW-1:0]             bit_idx, bit_nxt;
  logic [UART_DATA_BITS-1:0] shift, shift_nxt;
  logic                      txd_nxt;
  logic                      baud_done;

  logic                      push_req;
  logic                      push_ok;
  logic                      pop;
  logic [UART_DATA_BITS-1:0] fifo_dout;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [AW:0]               fifo_count;
  logic [AW:0]               count_nxt;

`ifdef UART_TX_PARITY_EN
  logic parity_q, parity_nxt;
`endif

  assign push_req  = ~_uart_in;
  // Full is judged before the pop, yet a same-cycle pop frees the slot.
  assign push_ok   = push_req & (~fifo_full | pop);
  assign baud_done = (baud == BAUD_LAST);
  assign tx_busy   = (state != IDLE) | ~fifo_empty;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_ok),
    .pop   (pop),
    .din   (data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // do_ready is registered from the post-edge occupancy so it never lags a fill.
  always_comb begin
    count_nxt = fifo_count;
    if (push_ok & ~pop)      count_nxt = fifo_count + CNT_ONE;
    else if (~push_ok & pop) count_nxt = fifo_count - CNT_ONE;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred; blocking '=' is correct here.
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    txd_nxt   = txd;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_nxt = parity_q;
`endif
    case (state)
      IDLE: begin
        baud_nxt = '0;
        txd_nxt  = UART_IDLE_LEVEL;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_nxt = fifo_dout;
          state_nxt = START;
          txd_nxt   = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_nxt = even_parity(fifo_dout);
`endif
        end
      end
      START: begin
        if (baud_done) begin
          baud_nxt  = '0;
          bit_nxt   = '0;
          state_nxt = DATA;
          txd_nxt   = shift[0];
        end else begin
          baud_nxt = baud + BAUD_ONE;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_nxt  = '0;
          shift_nxt = shift >> 1;
          if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
            txd_nxt   = parity_q;
`else
            state_nxt = STOP;
            txd_nxt   = UART_IDLE_LEVEL;
`endif
          end else begin
            bit_nxt = bit_idx + BIT_ONE;
            txd_nxt = shift[1];
          end
        end else begin
          baud_nxt = baud + BAUD_ONE;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_done) begin
          baud_nxt  = '0;
          state_nxt = STOP;
          txd_nxt   = UART_IDLE_LEVEL;
        end else begin
          baud_nxt = baud + BAUD_ONE;
        end
      end
`endif
      STOP: begin
        if (baud_done) begin
          baud_nxt = '0;
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_nxt = fifo_dout;
            state_nxt = START;
            txd_nxt   = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_nxt = even_parity(fifo_dout);
`endif
          end else begin
            state_nxt = IDLE;
            txd_nxt   = UART_IDLE_LEVEL;
          end
        end else begin
          baud_nxt = baud + BAUD_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        baud_nxt  = '0;
        txd_nxt   = UART_IDLE_LEVEL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      txd      <= UART_IDLE_LEVEL;
      do_ready <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud     <= baud_nxt;
      bit_idx  <= bit_nxt;
      shift    <= shift_nxt;
      txd      <= txd_nxt;
      do_ready <= (count_nxt != CNT_FULL);
      if (push_req & fifo_full & ~pop) overflow <= 1'b1;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) parity_q <= 1'b0;
    else       parity_q <= parity_nxt;
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected bytes, a line
// monitor decodes txd frames and checks them against the queue.
module tb_uart_tx_fifo;

  localparam int DEPTH = 4;
  localparam int CPB   = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       _uart_in = 1'b1;
  logic [7:0] data = 8'h00;
  logic       txd;
  logic       do_ready;
  logic       tx_busy;
  logic       overflow;

  uart_tx_fifo #(
    .DEPTH        (DEPTH),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    ._uart_in (_uart_in),
    .data     (data),
    .txd      (txd),
    .do_ready (do_ready),
    .tx_busy  (tx_busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  exp_q[$];
  int          start_q[$];
  int          frames = 0;
  logic [10:0] last_line = '0;
  logic        last_parity = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  // Line monitor: samples 1 time unit after each rising edge, mid-bit.
  initial begin
    logic       prev;
    bit         busy;
    int         off;
    int         bi;
    logic [7:0] rx;
    prev = 1'b1;
    busy = 1'b0;
    off  = 0;
    rx   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        busy = 1'b0;
        prev = 1'b1;
      end else begin
        if (busy) begin
          off++;
        end else if (prev === 1'b1 && txd === 1'b0) begin
          busy = 1'b1;
          off  = 0;
          last_line = '0;
          start_q.push_back(cyc);
        end
        if (busy && (off % CPB) == 2) begin
          bi = off / CPB;
          last_line[bi] = txd;
          if (bi == 0) check("start_bit", txd, 0);
          else if (bi <= 8) rx[bi-1] = txd;
          else if (bi == 9 && NBITS == 11) last_parity = txd;
          if (bi == NBITS - 1) begin
            check("stop_bit", txd, 1);
            frames++;
            if (exp_q.size() == 0) begin
              n_checks++;
              n_errors++;
              $display("FAIL unexpected_frame: got %0h expected none", rx);
            end else begin
              check("rx_byte", rx, exp_q.pop_front());
            end
            busy = 1'b0;
          end
        end
        prev = txd;
      end
    end
  end

  task automatic push_byte(input logic [7:0] b, input bit expect_tx);
    _uart_in = 1'b0;
    data     = b;
    if (expect_tx) exp_q.push_back(b);
    @(negedge clk);
    _uart_in = 1'b1;
  endtask

  task automatic wait_start(input int base, output int s);
    s = -1;
    for (int i = 0; i < 40; i++) begin
      if (start_q.size() > base) begin
        s = start_q[base];
        break;
      end
      @(negedge clk);
    end
    if (s < 0) timeout_fail("wait_start");
  endtask

  task automatic wait_drain(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !tx_busy) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!done) timeout_fail("wait_drain");
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         s;
    int         pe;
    int         base;
    int         base_f;
    bit         ok;
    logic [7:0] msg [6];
    logic [7:0] ov  [6];
    msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h21};
    ov  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    // Reset held for 3 edges.
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_do_ready", do_ready, 1);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single byte 'H'.
    base = start_q.size();
    pe = cyc + 1;
    push_byte(8'h48, 1'b1);
    wait_start(base, s);
    check("h_push_to_start_edges", s - pe, 1);
    wait_cyc(s + FRAME - 1);
    check("h_busy_before_end", tx_busy, 1);
    @(negedge clk);
    check("h_busy_dropped", tx_busy, 0);
`ifdef UART_TX_PARITY_EN
    check("h_line_bits", last_line, 11'h490);
`else
    check("h_line_bits", last_line, 11'h290);
`endif

    // "Hello!" as fast as do_ready allows.
    repeat (5) @(negedge clk);
    base = start_q.size();
    for (int i = 0; i < 6; i++) begin
      ok = 1'b0;
      for (int t = 0; t < 200; t++) begin
        if (do_ready) begin
          ok = 1'b1;
          break;
        end
        @(negedge clk);
      end
      if (!ok) timeout_fail("hello_do_ready");
      push_byte(msg[i], 1'b1);
      if (i == 3) check("hello_ready_after_3_queued", do_ready, 1);
      if (i == 4) check("hello_ready_low_after_4_queued", do_ready, 0);
    end
    wait_drain(600);
    check("hello_frames", start_q.size() - base, 6);
    if (start_q.size() - base == 6) begin
      for (int k = 1; k < 6; k++)
        check("hello_frame_spacing", start_q[base+k] - start_q[base+k-1], FRAME);
    end
    check("hello_overflow", overflow, 0);

    // Overflow: six consecutive pushes, the last one is dropped.
    repeat (5) @(negedge clk);
    base_f = frames;
    for (int i = 0; i < 6; i++) push_byte(ov[i], i < 5);
    check("ovf_flag", overflow, 1);
    wait_drain(600);
    repeat (20) @(negedge clk);
    check("ovf_frames_sent", frames - base_f, 5);
    check("ovf_flag_sticky", overflow, 1);

    // Reset in the middle of data bit 3 of 8'hA5.
    base = start_q.size();
    push_byte(8'hA5, 1'b0);
    wait_start(base, s);
    wait_cyc(s + 17);
    check("rst_mid_bit3_level", txd, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_txd", txd, 1);
    check("rst_mid_busy", tx_busy, 0);
    check("rst_mid_ready", do_ready, 1);
    check("rst_mid_overflow", overflow, 0);
    reset = 1'b0;
    base_f = frames;
    base = start_q.size();
    repeat (80) @(negedge clk);
    check("rst_mid_no_frames", frames - base_f, 0);
    check("rst_mid_no_starts", start_q.size() - base, 0);
    check("rst_mid_txd_idle", txd, 1);

`ifdef UART_TX_PARITY_EN
    // Parity frame for 8'h07.
    base = start_q.size();
    push_byte(8'h07, 1'b1);
    wait_start(base, s);
    wait_cyc(s + 43);
    check("par_busy_before_end", tx_busy, 1);
    @(negedge clk);
    check("par_busy_dropped", tx_busy, 0);
    check("par_bit", last_parity, 1);
    check("par_line_bits", last_line, 11'h60E);
`endif

    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered 8N1 UART transmitter that sits directly downstream of the CPU's `uart` target device. A byte written by an instruction targeting `uart` is pushed into a small FIFO and serialised LSB-first onto `txd` at a fixed baud rate. The block drives the CPU's `DO` condition flag, so a `CM_STD` `DO`-conditioned write stalls or skips when the FIFO is full. This gives programs like a "Hello!" string loop correct flow control without busy-wait timing.

## Interface
- `DEPTH`, 16: FIFO entries. Power of two, ≥2.
- `CLKS_PER_BIT`, 16: `clk` cycles per serial bit. Must be ≥2.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  reset: synchronous, active-high; sampled on rising edge of `clk`.
- `_uart_in`  in  1  active-low write strobe from the CPU target decode; one push per cycle it is low.
- `data`  in  8  byte to transmit; taken from the ALU result bus and sampled with `_uart_in`.
- `txd`  out  1  serial line; idles high.
- `do_ready`  out  1  `DO` flag: 1 when the FIFO can accept a byte (not full).
- `tx_busy`  out  1  1 while a frame is on the line or the FIFO is non-empty.
- `overflow`  out  1  sticky; set on a push while full; cleared only by `reset`.

## Operation
- Reset values: `txd`=1, `do_ready`=1, `tx_busy`=0, `overflow`=0. The FIFO is empty, the FSM is in IDLE, and the bit counter and baud counter are 0.
- Push: a rising edge with `_uart_in`=0 and not full writes `data` at the write pointer, and the write pointer increments modulo DEPTH.
- A push while full is dropped and sets `overflow`. The FIFO contents are unchanged.
- The FIFO count is log2(DEPTH)+1 bits wide. Full means count==DEPTH; empty means count==0. Pointers wrap naturally.
- Simultaneous push and pop in one cycle: both happen and the count is unchanged.
- When full, a push and a pop in the same cycle are both accepted, because full is evaluated before the pop.
- FSM states:
  - IDLE: `txd`=1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: `txd`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `txd`=shift[0] for CLKS_PER_BIT cycles, then shift right. After bit 7 go to PARITY if enabled, otherwise STOP.
  - PARITY (optional): `txd`=even parity of the byte for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: `txd`=1 for CLKS_PER_BIT cycles. Then, if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap); otherwise go to IDLE.
- The baud counter counts 0..CLKS_PER_BIT-1 within each state. It resets to 0 on every state transition.
- `txd` is driven from a register (glitch-free).
- `reset` asserted mid-frame aborts the frame and the FIFO is emptied. On the next edge after release `txd` is 1.

## Timing
- Push to `txd` falling edge, when idle and the FIFO is empty:
  - edge N writes the FIFO;
  - edge N+1 pops (IDLE→START);
  - `txd`=0 after edge N+1.
  - Latency is 2 cycles.
- Frame length is 10×CLKS_PER_BIT cycles, or 11×CLKS_PER_BIT with parity.
- `do_ready` is registered from the count and updates on the edge after the push or pop.
  - The CPU samples `DO` during its fetch phase. One cycle of staleness is tolerated, because a pending push cannot complete until the next edge.
- `tx_busy` = (state≠IDLE) | ~empty. It is combinational from registers.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - the PARITY state is compiled in;
  - the frame is 8E1 (11 bit times);
  - the parity bit is the XOR of data[7:0].
- Undefined: the PARITY state is absent and the frame is 8N1 (10 bit times).

## Structure
- Package `uart_pkg`:
  - `uart_state_t` enum with IDLE, START, DATA, PARITY, STOP;
  - `UART_DATA_BITS`=8;
  - `UART_IDLE_LEVEL`=1'b1.
- Sub-module `uart_sync_fifo`:
  - parameters `DEPTH` and `WIDTH`;
  - ports `push`, `pop`, `din`, `dout`, `full`, `empty`, `count`;
  - `dout` is valid combinationally from the read pointer.
- The top holds the FSM, baud counter, bit counter, shift register and the `overflow` flag.

## Test plan
Parameters for all scenarios: CLKS_PER_BIT=4, DEPTH=4.

- Reset: hold `reset` for 3 edges → `txd`=1, `do_ready`=1, `tx_busy`=0, `overflow`=0.
- Single byte 8'h48 ('H'):
  - the falling edge of `txd` occurs 2 cycles after the push;
  - the line carries 0,0,0,0,1,0,0,1,0,1 (start, LSB-first data, stop), 4 cycles each;
  - `tx_busy` drops after 40 cycles.
- "Hello!" back-to-back:
  - push 6 bytes as fast as `do_ready` allows;
  - `do_ready` goes low after the 4th queued byte;
  - 60 bit times with no idle gap;
  - the decoded bytes match the input;
  - `overflow`=0.
- Overflow:
  - push 6 bytes on consecutive cycles while the first is sending;
  - `overflow`=1 and exactly 5 bytes are transmitted (1 in the shift register + 4 in the FIFO).
- Reset mid-frame: assert `reset` during bit 3 of 8'hA5 → `txd`=1 next edge and no further frames.
- With `UART_TX_PARITY_EN`: send 8'h07 → parity bit 1 and a frame of 44 cycles.
